// File: rtl/pid_loop_sequencer_if.sv
// Signal bundle between the host control registers, the PID datapath and
// the loop sequencer. The sequencer attaches through the slave modport.
interface pid_loop_sequencer_if;
    logic        start;
    logic        abort;
    logic [31:0] target_in;
    logic [31:0] p_meas;
    logic        pid_rst_n;
    logic [31:0] pid_target;
    logic        busy;
    logic        settled;
    logic        done;
    logic        fault;

    modport master (
        output start, abort, target_in, p_meas,
        input  pid_rst_n, pid_target, busy, settled, done, fault
    );

    modport slave (
        input  start, abort, target_in, p_meas,
        output pid_rst_n, pid_target, busy, settled, done, fault
    );
endinterface

// File: rtl/pid_loop_sequencer.sv
// Optical-power PID loop sequencer: start-up, setpoint ramp, settle detection,
// hold and fault shutdown. Setpoints and power are unsigned Q9.23.
module pid_loop_sequencer #(
    parameter int          TICK_DIV   = 100,
    parameter logic [31:0] RAMP_STEP  = 32'd8389,
    parameter logic [31:0] SETTLE_TOL = 32'd4194,
    parameter int          SETTLE_CNT = 16,
    parameter logic [15:0] TIMEOUT    = 16'd1000
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    pid_loop_sequencer_if.slave seq_io
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_RAMP   = 3'd1;
    localparam logic [2:0] S_SETTLE = 3'd2;
    localparam logic [2:0] S_HOLD   = 3'd3;
    localparam logic [2:0] S_FAULT  = 3'd4;

    localparam int            TW        = $clog2(TICK_DIV);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [7:0]    BAND_DONE = 8'(SETTLE_CNT);

    logic [2:0]    state_q, state_d;
    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
    logic [7:0]    band_cnt_q, band_cnt_d;
    logic [15:0]   timeout_cnt_q, timeout_cnt_d;
    logic [31:0]   tgt_q, tgt_d;
    logic [31:0]   pid_target_q, pid_target_d;
    logic          pid_rst_n_q, pid_rst_n_d;
    logic          busy_q, busy_d;
    logic          settled_q, settled_d;
    logic          done_q, done_d;
    logic          fault_q, fault_d;

    logic        tick;
    logic [31:0] p_diff;
    logic        in_band;
    logic        ramp_up;
    logic [31:0] ramp_gap;
    logic [31:0] ramp_next;
    logic [7:0]  band_inc;
    logic [15:0] timeout_inc;

    assign tick     = (tick_cnt_q == TICK_LAST);
    assign p_diff   = (seq_io.p_meas >= pid_target_q) ? (seq_io.p_meas - pid_target_q)
                                                      : (pid_target_q - seq_io.p_meas);
    assign in_band  = (p_diff <= SETTLE_TOL);

    // The remaining gap is measured before stepping, so the step never overshoots or wraps.
    assign ramp_up   = (tgt_q >= pid_target_q);
    assign ramp_gap  = ramp_up ? (tgt_q - pid_target_q) : (pid_target_q - tgt_q);
    assign ramp_next = (ramp_gap <= RAMP_STEP) ? tgt_q
                     : (ramp_up ? (pid_target_q + RAMP_STEP) : (pid_target_q - RAMP_STEP));

    assign band_inc    = band_cnt_q + 8'd1;
    assign timeout_inc = timeout_cnt_q + 16'd1;

    always_comb begin
        state_d       = state_q;
        tick_cnt_d    = tick ? '0 : (tick_cnt_q + TW'(1));
        band_cnt_d    = band_cnt_q;
        timeout_cnt_d = timeout_cnt_q;
        tgt_d         = tgt_q;
        pid_target_d  = pid_target_q;
        pid_rst_n_d   = pid_rst_n_q;
        busy_d        = busy_q;
        settled_d     = settled_q;
        done_d        = 1'b0;
        fault_d       = fault_q;

        case (state_q)
            S_IDLE: begin
                tick_cnt_d = '0;
                if (seq_io.start) begin
                    tgt_d       = seq_io.target_in;
                    state_d     = S_RAMP;
                    pid_rst_n_d = 1'b1;
                    busy_d      = 1'b1;
                end
            end
            S_RAMP: begin
                if (tick) begin
                    pid_target_d = ramp_next;
                    if (ramp_next == tgt_q) begin
                        state_d       = S_SETTLE;
                        band_cnt_d    = '0;
                        timeout_cnt_d = '0;
                    end
                end
            end
            S_SETTLE: begin
                if (tick) begin
                    band_cnt_d = in_band ? band_inc : 8'd0;
                    // Settling takes precedence over a timeout landing on the same tick.
                    if (in_band && (band_inc == BAND_DONE)) begin
                        state_d   = S_HOLD;
                        done_d    = 1'b1;
                        settled_d = 1'b1;
                        busy_d    = 1'b0;
                    end else begin
                        timeout_cnt_d = timeout_inc;
                        if (timeout_inc == TIMEOUT) begin
                            state_d      = S_FAULT;
                            pid_rst_n_d  = 1'b0;
                            pid_target_d = '0;
                            busy_d       = 1'b0;
                            fault_d      = 1'b1;
                        end
                    end
                end
            end
            S_HOLD: begin
                if (tick) begin
                    settled_d = in_band;
                end
                if (seq_io.start) begin
                    tgt_d      = seq_io.target_in;
                    state_d    = S_RAMP;
                    busy_d     = 1'b1;
                    settled_d  = 1'b0;
                    tick_cnt_d = '0;
                end
            end
            S_FAULT: begin
                tick_cnt_d = '0;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (seq_io.abort) begin
            state_d       = S_IDLE;
            tick_cnt_d    = '0;
            band_cnt_d    = '0;
            timeout_cnt_d = '0;
            tgt_d         = '0;
            pid_target_d  = '0;
            pid_rst_n_d   = 1'b0;
            busy_d        = 1'b0;
            settled_d     = 1'b0;
            done_d        = 1'b0;
            fault_d       = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q       <= S_IDLE;
            tick_cnt_q    <= '0;
            band_cnt_q    <= '0;
            timeout_cnt_q <= '0;
            tgt_q         <= '0;
            pid_target_q  <= '0;
            pid_rst_n_q   <= 1'b0;
            busy_q        <= 1'b0;
            settled_q     <= 1'b0;
            done_q        <= 1'b0;
            fault_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            tick_cnt_q    <= tick_cnt_d;
            band_cnt_q    <= band_cnt_d;
            timeout_cnt_q <= timeout_cnt_d;
            tgt_q         <= tgt_d;
            pid_target_q  <= pid_target_d;
            pid_rst_n_q   <= pid_rst_n_d;
            busy_q        <= busy_d;
            settled_q     <= settled_d;
            done_q        <= done_d;
            fault_q       <= fault_d;
        end
    end

    assign seq_io.pid_rst_n  = pid_rst_n_q;
    assign seq_io.pid_target = pid_target_q;
    assign seq_io.busy       = busy_q;
    assign seq_io.settled    = settled_q;
    assign seq_io.done       = done_q;
    assign seq_io.fault      = fault_q;

endmodule
